// File: rtl/mem_arbiter_pkg.sv
// Shared CPU package: default widths, arbiter FSM encoding and sizing helpers.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int MAX_DATA_RUN_DEF = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_I_RESP = 2'd1;
  localparam logic [1:0] ST_D_RESP = 2'd2;

  // Bits needed to count 0..max_run inclusive; never narrower than one bit.
  function automatic int run_cnt_w(input int max_run);
    return (max_run < 1) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port SRAM: grant and SRAM drive are combinational, data_ok one cycle later.
// No internal queueing; a requester that is not granted simply holds its request, so throughput is one access per cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int CNT_W = run_cnt_w(MAX_DATA_RUN);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             inst_starved;
  logic             inst_gnt;
  logic             data_gnt;

  // Data normally wins; once it has taken MAX_DATA_RUN grants past a waiting
  // fetch, the fetch gets one turn. Grants are masked while reset is held so
  // every output is quiet during reset.
  always_comb begin
    inst_starved = inst_req && (run_cnt_q == RUN_MAX);
    data_gnt     = resetn && data_req && !inst_starved;
    inst_gnt     = resetn && inst_req && !data_gnt;
  end

  // Each RESP state lasts exactly one cycle, so the next state depends only
  // on this cycle's grant and a new grant is allowed from any state.
  always_comb begin
    state_d = ST_IDLE;
    if (inst_gnt) begin
      state_d = ST_I_RESP;
    end else if (data_gnt) begin
      state_d = ST_D_RESP;
    end
  end

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (!inst_req || inst_gnt) begin
      run_cnt_d = '0;
    end else if (data_gnt && (run_cnt_q != RUN_MAX)) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  always_comb begin
    sram_en      = inst_gnt || data_gnt;
    sram_wen     = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    inst_addr_ok = inst_gnt;
    data_addr_ok = data_gnt;
    if (data_gnt) begin
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
      sram_wen   = data_wr ? data_wstrb : '0;
    end else if (inst_gnt) begin
      sram_addr  = inst_addr;
    end
  end

  // Response side: stores also get data_data_ok; rdata is zeroed off-response.
  always_comb begin
    inst_data_ok = (state_q == ST_I_RESP);
    data_data_ok = (state_q == ST_D_RESP);
    inst_rdata   = inst_data_ok ? sram_rdata : '0;
    data_rdata   = data_data_ok ? sram_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 ns after the rising edge, outputs are checked 1 ns later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag);
    chk({tag, " sram_en"},      32'(sram_en),      32'h0);
    chk({tag, " sram_wen"},     32'(sram_wen),     32'h0);
    chk({tag, " inst_addr_ok"}, 32'(inst_addr_ok), 32'h0);
    chk({tag, " data_addr_ok"}, 32'(data_addr_ok), 32'h0);
    chk({tag, " inst_data_ok"}, 32'(inst_data_ok), 32'h0);
    chk({tag, " data_data_ok"}, 32'(data_data_ok), 32'h0);
    chk({tag, " inst_rdata"},   inst_rdata,        32'h0);
    chk({tag, " data_rdata"},   data_rdata,        32'h0);
  endtask

  initial begin
    bit exp_d [6];
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    resetn = 1'b0; inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    sram_rdata = 32'h5555_AAAA;
    tick();
    // Requests raised while reset is held must not reach the SRAM.
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h40; data_addr = 32'h80;
    #1;
    quiet("reset");
    tick();

    // First cycle out of reset: single fetch.
    resetn = 1'b1; data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    #1;
    chk("fetch addr_ok", 32'(inst_addr_ok), 32'h1);
    chk("fetch sram_en", 32'(sram_en), 32'h1);
    chk("fetch sram_addr", sram_addr, 32'hBFC0_0000);
    chk("fetch sram_wen", 32'(sram_wen), 32'h0);
    tick();
    inst_req = 1'b0; sram_rdata = 32'h3C1D_0001;
    #1;
    chk("fetch data_ok", 32'(inst_data_ok), 32'h1);
    chk("fetch rdata", inst_rdata, 32'h3C1D_0001);
    chk("fetch no data_data_ok", 32'(data_data_ok), 32'h0);
    chk("fetch resp sram_en", 32'(sram_en), 32'h0);
    tick();
    quiet("idle");

    // Contention: store wins, fetch goes next cycle.
    inst_req = 1'b1; inst_addr = 32'h200;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h100; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    #1;
    chk("cont data_addr_ok", 32'(data_addr_ok), 32'h1);
    chk("cont inst_addr_ok", 32'(inst_addr_ok), 32'h0);
    chk("cont sram_addr", sram_addr, 32'h100);
    chk("cont sram_wen", 32'(sram_wen), 32'hF);
    chk("cont sram_wdata", sram_wdata, 32'hDEAD_BEEF);
    tick();
    data_req = 1'b0; data_wr = 1'b0; sram_rdata = 32'h1111_1111;
    #1;
    chk("cont inst_addr_ok2", 32'(inst_addr_ok), 32'h1);
    chk("cont sram_addr2", sram_addr, 32'h200);
    chk("cont sram_wen2", 32'(sram_wen), 32'h0);
    chk("cont data_data_ok", 32'(data_data_ok), 32'h1);
    tick();
    inst_req = 1'b0; sram_rdata = 32'h2222_2222;
    #1;
    chk("cont inst_data_ok", 32'(inst_data_ok), 32'h1);
    chk("cont inst_rdata", inst_rdata, 32'h2222_2222);
    chk("cont no data_data_ok", 32'(data_data_ok), 32'h0);
    tick();

    // Both held for six cycles: fairness pattern D,D,D,I,D,D.
    inst_req = 1'b1; inst_addr = 32'h1000; data_req = 1'b1; data_wr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      data_addr  = 32'h300 + 32'(4 * k);
      sram_rdata = 32'hA000_0000 + 32'(k);
      #1;
      chk($sformatf("run%0d data_addr_ok", k), 32'(data_addr_ok), 32'(exp_d[k]));
      chk($sformatf("run%0d inst_addr_ok", k), 32'(inst_addr_ok), 32'(!exp_d[k]));
      if (k > 0) begin
        chk($sformatf("run%0d data_data_ok", k), 32'(data_data_ok), 32'(exp_d[k-1]));
        chk($sformatf("run%0d inst_data_ok", k), 32'(inst_data_ok), 32'(!exp_d[k-1]));
        chk($sformatf("run%0d rdata", k), exp_d[k-1] ? data_rdata : inst_rdata,
            32'hA000_0000 + 32'(k));
      end
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; sram_rdata = 32'hA000_0006;
    #1;
    chk("run tail data_data_ok", 32'(data_data_ok), 32'h1);
    chk("run tail data_rdata", data_rdata, 32'hA000_0006);
    tick();

    // Sub-word stores, back to back: empty strobe then 0x3.
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h400; data_wstrb = 4'h0; data_wdata = 32'h1234_5678;
    #1;
    chk("strb0 sram_en", 32'(sram_en), 32'h1);
    chk("strb0 sram_wen", 32'(sram_wen), 32'h0);
    chk("strb0 addr_ok", 32'(data_addr_ok), 32'h1);
    tick();
    data_wstrb = 4'h3; data_addr = 32'h404;
    #1;
    chk("strb3 sram_wen", 32'(sram_wen), 32'h3);
    chk("strb0 data_ok", 32'(data_data_ok), 32'h1);
    tick();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    #1;
    chk("strb3 data_ok", 32'(data_data_ok), 32'h1);
    tick();

    // Reset asserted while a load response is pending.
    data_req = 1'b1; data_addr = 32'h500;
    #1;
    chk("rst load addr_ok", 32'(data_addr_ok), 32'h1);
    tick();
    resetn = 1'b0;
    #1;
    quiet("rst held");
    tick();
    quiet("rst held edge");
    resetn = 1'b1; data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h600;
    #1;
    chk("rst release inst_addr_ok", 32'(inst_addr_ok), 32'h1);
    chk("rst release no data_ok", 32'(data_data_ok), 32'h0);
    tick();
    inst_req = 1'b0; sram_rdata = 32'h0600_0600;
    #1;
    chk("rst after inst_data_ok", 32'(inst_data_ok), 32'h1);
    chk("rst after no data_data_ok", 32'(data_data_ok), 32'h0);
    tick();

    // Back-to-back fetches with no bubble.
    inst_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inst_addr  = 32'(4 * k);
      sram_rdata = 32'hF000_0000 + 32'(k);
      #1;
      chk($sformatf("b2b%0d addr_ok", k), 32'(inst_addr_ok), 32'h1);
      chk($sformatf("b2b%0d sram_addr", k), sram_addr, 32'(4 * k));
      chk($sformatf("b2b%0d data_ok", k), 32'(inst_data_ok), 32'(k > 0));
      tick();
    end
    inst_req = 1'b0; sram_rdata = 32'hF000_0003;
    #1;
    chk("b2b tail data_ok", 32'(inst_data_ok), 32'h1);
    chk("b2b tail rdata", inst_rdata, 32'hF000_0003);
    tick();
    quiet("final idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
